// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path:
// next-PC select codes, fetch state encoding and memory map defaults.
package mips_pkg;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Next-PC target selection with legality and
// end-of-memory detection against the instruction window.
module npc_calc
  import mips_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int          IM_WORDS = DEF_IM_WORDS
) (
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] reg_target,
  output logic [31:0] target,
  output logic        legal,
  output logic        at_end
);

  // 33-bit bounds so the window top never wraps
  localparam logic [32:0] IM_LO  = {1'b0, IM_BASE};
  localparam logic [32:0] IM_END = IM_LO + 33'(4 * IM_WORDS);

  logic [31:0] seq;
  logic [31:0] br_off;

  assign seq    = pc + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = seq;
    unique case (npc_op)
      NPC_PC4: target = seq;
      NPC_BR:  target = br_taken ? seq + br_off : seq;
      NPC_J:   target = {pc[31:28], instr_index, 2'b00};
      NPC_JR:  target = reg_target;
    endcase
  end

  assign legal = (target[1:0] == 2'b00)
              && ({1'b0, target} >= IM_LO)
              && ({1'b0, target} < IM_END);

  assign at_end = (npc_op == NPC_PC4)
               && (({1'b0, pc} + 33'd4) == IM_END);

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: PC register, fetch FSM and
// saturating retired-instruction counter.
module fetch_seq
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int          IM_WORDS = DEF_IM_WORDS,
  parameter int          AW       = $clog2(IM_WORDS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          stall,
  input  logic [1:0]    npc_op,
  input  logic          br_taken,
  input  logic [15:0]   imm16,
  input  logic [25:0]   instr_index,
  input  logic [31:0]   reg_target,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [AW-1:0] im_addr,
  output logic          fetch_valid,
  output logic          halted,
  output logic          exc_addr,
  output logic [31:0]   fetch_count
);

  fetch_state_t state;
  logic [31:0]  target;
  logic         legal;
  logic         at_end;

  npc_calc #(
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) u_npc (
    .pc          (pc),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .reg_target  (reg_target),
    .target      (target),
    .legal       (legal),
    .at_end      (at_end)
  );

  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = AW'((pc - IM_BASE) >> 2);

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_RST;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      exc_addr    <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        ST_RST: begin
          state       <= ST_RUN;
          fetch_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!stall) begin
            if (fetch_count != '1)
              fetch_count <= fetch_count + 32'd1;
            if (legal) begin
              pc <= target;
            end else if (at_end) begin
              state       <= ST_HALT;
              halted      <= 1'b1;
              fetch_valid <= 1'b0;
            end else begin
              state       <= ST_FAULT;
              exc_addr    <= 1'b1;
              fetch_valid <= 1'b0;
            end
          end
        end
        ST_HALT, ST_FAULT: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed and randomized checks of fetch_seq
// against a behavioural next-PC model.
module tb_fetch_seq;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 1024;
  localparam longint      TOP   = longint'(BASE) + 4 * WORDS;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] reg_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [9:0]  im_addr;
  logic        fetch_valid;
  logic        halted;
  logic        exc_addr;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_pc = BASE;
  logic [31:0] m_cnt = '0;
  bit          m_rst = 1'b1;
  bit          m_halt = 1'b0;
  bit          m_fault = 1'b0;

  fetch_seq dut (
    .clk         (clk),
    .clr         (clr),
    .stall       (stall),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .reg_target  (reg_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .im_addr     (im_addr),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .exc_addr    (exc_addr),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    return !m_rst && !m_halt && !m_fault;
  endfunction

  task automatic model_step();
    logic [31:0] t;
    bit ok;
    if (clr) begin
      m_pc = BASE; m_cnt = 0;
      m_rst = 1; m_halt = 0; m_fault = 0;
    end else if (m_rst) begin
      m_rst = 0;
    end else if (!m_halt && !m_fault && !stall) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      case (npc_op)
        2'd0: t = m_pc + 4;
        2'd1: begin
          t = m_pc + 4;
          if (br_taken)
            t = t + 32'(int'($signed(imm16)) * 4);
        end
        2'd2: t = (m_pc & 32'hF000_0000)
                | (32'(instr_index) * 4);
        default: t = reg_target;
      endcase
      ok = (t % 4 == 0) && (t >= BASE)
        && (longint'(t) < TOP);
      if (ok) m_pc = t;
      else if (npc_op == 2'd0
               && longint'(m_pc) + 4 == TOP)
        m_halt = 1;
      else m_fault = 1;
    end
  endtask

  task automatic tick(input bit c, input bit s,
                      input logic [1:0] op,
                      input bit br,
                      input logic [15:0] imm,
                      input logic [25:0] idx,
                      input logic [31:0] rt);
    clr = c; stall = s; npc_op = op;
    br_taken = br; imm16 = imm;
    instr_index = idx; reg_target = rt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++)
      tick(0, 0, 2'd0, 0, '0, '0, '0);
  endtask

  task automatic jr(input logic [31:0] a);
    tick(0, 0, 2'd3, 0, '0, '0, a);
  endtask

  task automatic do_reset();
    tick(1, 0, 2'd0, 0, '0, '0, '0);
    tick(1, 0, 2'd0, 0, '0, '0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (pc !== 32'h3000 || pc_plus4 !== 32'h3004
        || im_addr !== 10'd0 || fetch_valid !== 1'b0
        || halted !== 1'b0 || exc_addr !== 1'b0
        || fetch_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: pc=%h p4=%h ia=%0d v=%b h=%b e=%b c=%0d",
               pc, pc_plus4, im_addr, fetch_valid,
               halted, exc_addr, fetch_count);
    end
  endtask

  task automatic test_seq();
    logic [31:0] epc [3];
    epc[0] = 32'h3000; epc[1] = 32'h3004; epc[2] = 32'h3008;
    tick(0, 0, 2'd0, 0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (pc !== epc[i] || im_addr !== 10'(i)
          || fetch_count !== 32'(i)
          || fetch_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL seq%0d: pc=%h ia=%0d c=%0d v=%b want pc=%h",
                 i, pc, im_addr, fetch_count, fetch_valid,
                 epc[i]);
      end
      if (i < 2) seq(1);
    end
  endtask

  task automatic test_branch();
    jr(32'h3010);
    tick(0, 0, 2'd1, 1, 16'hFFFC, '0, '0);
    vectors++;
    if (pc !== 32'h3004) begin
      miscompares++;
      $display("FAIL br_taken: pc=%h want 3004", pc);
    end
    jr(32'h3010);
    tick(0, 0, 2'd1, 0, 16'hFFFC, '0, '0);
    vectors++;
    if (pc !== 32'h3014) begin
      miscompares++;
      $display("FAIL br_not_taken: pc=%h want 3014", pc);
    end
  endtask

  task automatic test_jump_fault();
    jr(32'h3000);
    tick(0, 0, 2'd2, 0, '0, 26'h0000C08, '0);
    vectors++;
    if (pc !== 32'h3020) begin
      miscompares++;
      $display("FAIL jump: pc=%h want 3020", pc);
    end
    jr(32'h3002);
    vectors++;
    if (exc_addr !== 1'b1 || pc !== 32'h3020
        || fetch_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL fault: e=%b pc=%h v=%b h=%b want 1/3020/0/0",
               exc_addr, pc, fetch_valid, halted);
    end
    seq(2);
    vectors++;
    if (pc !== 32'h3020 || exc_addr !== 1'b1
        || fetch_count !== m_cnt) begin
      miscompares++;
      $display("FAIL fault_hold: pc=%h e=%b c=%0d want c=%0d",
               pc, exc_addr, fetch_count, m_cnt);
    end
  endtask

  task automatic test_clr_over_stall();
    tick(1, 1, 2'd0, 0, '0, '0, '0);
    vectors++;
    if (exc_addr !== 1'b0 || pc !== 32'h3000
        || fetch_valid !== 1'b0 || fetch_count !== 0) begin
      miscompares++;
      $display("FAIL clr_stall: e=%b pc=%h v=%b c=%0d",
               exc_addr, pc, fetch_valid, fetch_count);
    end
    tick(0, 1, 2'd0, 0, '0, '0, '0);
    vectors++;
    if (fetch_valid !== 1'b1 || pc !== 32'h3000) begin
      miscompares++;
      $display("FAIL rst_one_cycle: v=%b pc=%h want 1/3000",
               fetch_valid, pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    jr(32'h3008);
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 2'd3, 0, '0, '0, 32'h3002);
      vectors++;
      if (pc !== 32'h3008 || fetch_count !== c0
          || fetch_valid !== 1'b1 || exc_addr !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d: pc=%h c=%0d v=%b e=%b want c=%0d",
                 i, pc, fetch_count, fetch_valid, exc_addr, c0);
      end
    end
    seq(1);
    vectors++;
    if (pc !== 32'h300C || fetch_count !== c0 + 1) begin
      miscompares++;
      $display("FAIL stall_release: pc=%h c=%0d want 300c/%0d",
               pc, fetch_count, c0 + 1);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick(0, 0, 2'd0, 0, '0, '0, '0);
    seq(1023);
    vectors++;
    if (pc !== 32'h3FFC || im_addr !== 10'd1023
        || halted !== 1'b0 || fetch_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL last_word: pc=%h ia=%0d h=%b v=%b",
               pc, im_addr, halted, fetch_valid);
    end
    seq(1);
    vectors++;
    if (halted !== 1'b1 || fetch_count !== 32'd1024
        || pc !== 32'h3FFC || fetch_valid !== 1'b0
        || exc_addr !== 1'b0) begin
      miscompares++;
      $display("FAIL halt: h=%b c=%0d pc=%h v=%b e=%b",
               halted, fetch_count, pc, fetch_valid, exc_addr);
    end
    seq(2);
    vectors++;
    if (pc !== 32'h3FFC || fetch_count !== 32'd1024) begin
      miscompares++;
      $display("FAIL halt_hold: pc=%h c=%0d", pc, fetch_count);
    end
    tick(1, 0, 2'd0, 0, '0, '0, '0);
    vectors++;
    if (pc !== 32'h3000 || pc_plus4 !== 32'h3004
        || im_addr !== 0 || halted !== 1'b0
        || fetch_valid !== 1'b0 || fetch_count !== 0) begin
      miscompares++;
      $display("FAIL halt_clr: pc=%h p4=%h ia=%0d h=%b v=%b c=%0d",
               pc, pc_plus4, im_addr, halted, fetch_valid,
               fetch_count);
    end
  endtask

  task automatic test_random();
    int stuck = 0;
    bit c, s, br;
    logic [1:0] op;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      c  = ($urandom_range(0, 99) < 2) || stuck > 3;
      s  = $urandom_range(0, 99) < 20;
      op = 2'($urandom_range(0, 3));
      br = 1'($urandom);
      imm = 16'($signed($urandom_range(0, 40)) - 20);
      idx = 26'(32'h0C00 + $urandom_range(0, 1023));
      rt = BASE + 32'($urandom_range(0, 1023)) * 4;
      if ($urandom_range(0, 99) < 4) rt = $urandom;
      if ($urandom_range(0, 99) < 3) idx = 26'($urandom);
      tick(c, s, op, br, imm, idx, rt);
      stuck = (m_halt || m_fault) ? stuck + 1 : 0;
      vectors++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 4
          || im_addr !== 10'((m_pc - BASE) / 4)
          || fetch_valid !== m_valid()
          || halted !== m_halt || exc_addr !== m_fault
          || fetch_count !== m_cnt) begin
        miscompares++;
        $display("FAIL rand%0d: pc=%h/%h v=%b/%b h=%b/%b e=%b/%b c=%0d/%0d",
                 n, pc, m_pc, fetch_valid, m_valid(),
                 halted, m_halt, exc_addr, m_fault,
                 fetch_count, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jump_fault();
    test_clr_over_stall();
    test_stall();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
